hsv2rgb: RTL and testbench

- Converts one HSV sample into a packed 15-bit RGB pixel; the inverse of the pixel-to-HSV conversion in the ball-detector datapath.
- Saturation is absolute chroma (max − min), not a ratio. Value is max.
- Used to render detector overlays and to feed round-trip checks back into the camera-side pixel path.
- One conversion in flight at a time; fixed latency; start/done handshake.

---
 rtl/hsv2rgb_pkg.sv | 41 ++++
 rtl/hsv2rgb_div.sv | 67 ++++++
 rtl/hsv2rgb.sv | 151 +++++++++++++++
 tb/tb_hsv2rgb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv2rgb_pkg.sv
// Shared definitions for the HSV/RGB colour path: FSM encoding, hue geometry,
// sector codes and the packed 5:5:5 pixel field layout.
package hsv2rgb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SECTOR = 3'd1,
      MUL    = 3'd2,
      DIV    = 3'd3,
      ASM    = 3'd4
   } state_t;

   localparam int HUE_MAX  = 360;
   localparam int SECTOR_W = 60;

   localparam logic [8:0] HUE_MAX_9  = 9'(HUE_MAX);
   localparam logic [6:0] SECTOR_W_7 = 7'(SECTOR_W);

   localparam int MUL_CYCLES = 5;
   localparam int DIV_CYCLES = 11;

   localparam logic [2:0] SEC_0 = 3'd0;
   localparam logic [2:0] SEC_1 = 3'd1;
   localparam logic [2:0] SEC_2 = 3'd2;
   localparam logic [2:0] SEC_3 = 3'd3;
   localparam logic [2:0] SEC_4 = 3'd4;
   localparam logic [2:0] SEC_5 = 3'd5;

   // Packed pixel is {1'b0, r, g, b}; the HSV converter uses the same layout.
   localparam int R_HI = 14;
   localparam int R_LO = 10;
   localparam int G_HI = 9;
   localparam int G_LO = 5;
   localparam int B_HI = 4;
   localparam int B_LO = 0;

   function automatic logic [8:0] sector_base(input logic [2:0] sec);
      return 9'(SECTOR_W * int'(sec));
   endfunction

endpackage

// File: rtl/hsv2rgb_div.sv
// Sequential divide-by-60: 11-step restoring division of an 11-bit dividend.
// The first step runs on the start edge; done pulses the cycle after the last step.
module div_by60_seq
   import hsv2rgb_pkg::*;
(
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic [10:0] dividend,
   output logic        done,
   output logic [4:0]  quotient
);

   logic [5:0]  rem;
   logic [10:0] dvd;
   logic [4:0]  quo;
   logic [3:0]  count;
   logic        active;

   logic [5:0]  src_rem;
   logic [10:0] src_dvd;
   logic [4:0]  src_quo;
   logic [6:0]  trial;
   logic        ge;
   logic [5:0]  new_rem;

   // Only the low five quotient bits are kept; for valid products the quotient never exceeds 30.
   always_comb begin
      src_rem = start ? 6'd0 : rem;
      src_dvd = start ? dividend : dvd;
      src_quo = start ? 5'd0 : quo;
      trial   = {src_rem, src_dvd[10]};
      ge      = (trial >= SECTOR_W_7);
      new_rem = 6'(ge ? (trial - SECTOR_W_7) : trial);
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         rem    <= 6'd0;
         dvd    <= 11'd0;
         quo    <= 5'd0;
         count  <= 4'd0;
         active <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || active) begin
            rem <= new_rem;
            dvd <= {src_dvd[9:0], 1'b0};
            quo <= {src_quo[3:0], ge};
         end
         if (start) begin
            count  <= 4'd1;
            active <= 1'b1;
         end else if (active) begin
            count <= count + 4'd1;
            if (count == 4'(DIV_CYCLES - 1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo;

endmodule

// File: rtl/hsv2rgb.sv
// HSV to packed 5:5:5 RGB converter with a fixed 18-edge latency; saturation
// is absolute chroma (max - min) and value is the max channel.
module hsv2rgb
   import hsv2rgb_pkg::*;
(
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic [8:0]  hue,
   input  logic [4:0]  saturation,
   input  logic [4:0]  value,
   input  logic        hue_invalid,
   output logic [15:0] data,
   output logic        done,
   output logic        busy,
   output logic        range_err
);

   state_t      state, state_next;
   logic [3:0]  cnt;

   logic [8:0]  h;
   logic [4:0]  s, v, mn;
   logic        inv, grey;
   logic [2:0]  sector;
   logic [10:0] p, mcand;
   logic [4:0]  mplier;

   logic [2:0]  sec_c;
   logic [5:0]  f_c;
   logic [4:0]  rise, fall, r_c, g_c, b_c;
   logic        div_start, div_done;
   logic [4:0]  q;

   always_ff @(posedge clk) begin
      if (!res) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SECTOR;
         SECTOR:  state_next = MUL;
         MUL:     if (cnt == 4'(MUL_CYCLES - 1)) state_next = DIV;
         DIV:     if (cnt == 4'(DIV_CYCLES - 1)) state_next = ASM;
         ASM:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      div_start = (state == DIV) && (cnt == 4'd0);
   end

   // Out-of-range hues fall into sector 5 with a truncated offset; they are forced grey anyway.
   always_comb begin
      sec_c = SEC_0;
      if      (h >= sector_base(SEC_5)) sec_c = SEC_5;
      else if (h >= sector_base(SEC_4)) sec_c = SEC_4;
      else if (h >= sector_base(SEC_3)) sec_c = SEC_3;
      else if (h >= sector_base(SEC_2)) sec_c = SEC_2;
      else if (h >= sector_base(SEC_1)) sec_c = SEC_1;
      f_c = 6'(h - sector_base(sec_c));
   end

   always_comb begin
      rise = mn + q;
      fall = v - q;
      r_c  = v;
      g_c  = v;
      b_c  = v;
      if (!grey) begin
         case (sector)
            SEC_0:   begin r_c = v;    g_c = rise; b_c = mn;   end
            SEC_1:   begin r_c = fall; g_c = v;    b_c = mn;   end
            SEC_2:   begin r_c = mn;   g_c = v;    b_c = rise; end
            SEC_3:   begin r_c = mn;   g_c = fall; b_c = v;    end
            SEC_4:   begin r_c = rise; g_c = mn;   b_c = v;    end
            default: begin r_c = v;    g_c = mn;   b_c = fall; end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         cnt       <= 4'd0;
         h         <= 9'd0;
         s         <= 5'd0;
         v         <= 5'd0;
         mn        <= 5'd0;
         inv       <= 1'b0;
         grey      <= 1'b0;
         sector    <= 3'd0;
         p         <= 11'd0;
         mcand     <= 11'd0;
         mplier    <= 5'd0;
         data      <= 16'd0;
         done      <= 1'b0;
         range_err <= 1'b0;
      end else begin
         done <= 1'b0;
         cnt  <= (state_next != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
         case (state)
            IDLE: begin
               if (start) begin
                  h         <= hue;
                  s         <= (saturation < value) ? saturation : value;
                  v         <= value;
                  inv       <= hue_invalid;
                  range_err <= (hue >= HUE_MAX_9);
               end
            end
            SECTOR: begin
               sector <= sec_c;
               grey   <= inv | range_err | (s == 5'd0);
               mn     <= v - s;
               p      <= 11'd0;
               mcand  <= {5'd0, f_c};
               mplier <= s;
            end
            MUL: begin
               if (mplier[0]) p <= p + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end
            ASM: begin
               if (div_done) begin
                  data[15]        <= 1'b0;
                  data[R_HI:R_LO] <= r_c;
                  data[G_HI:G_LO] <= g_c;
                  data[B_HI:B_LO] <= b_c;
                  done            <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   div_by60_seq u_div (
      .clk      (clk),
      .res      (res),
      .start    (div_start),
      .dividend (p),
      .done     (div_done),
      .quotient (q)
   );

endmodule

// File: tb/tb_hsv2rgb.sv
// Self-checking bench for hsv2rgb: directed vector table, handshake/reset
// sequences, randomized conversions against an arithmetic model, and an RGB->HSV->RGB round trip.
`timescale 1ns/1ps
module tb_hsv2rgb;

   logic        clk = 1'b0;
   logic        res, start, hue_invalid;
   logic [8:0]  hue;
   logic [4:0]  saturation, value;
   logic [15:0] data;
   logic        done, busy, range_err;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   typedef struct {
      logic [8:0]  h;
      logic [4:0]  s;
      logic [4:0]  v;
      logic        inv;
      logic [15:0] d;
      logic        re;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   hsv2rgb dut (
      .clk         (clk),
      .res         (res),
      .start       (start),
      .hue         (hue),
      .saturation  (saturation),
      .value       (value),
      .hue_invalid (hue_invalid),
      .data        (data),
      .done        (done),
      .busy        (busy),
      .range_err   (range_err)
   );

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: sector = hue/60, offset = hue%60, ramp = floor(S*offset/60).
   function automatic logic [16:0] refModel(input int h, input int s, input int v, input bit inv);
      int se, mn, q, rise, fall, r, g, b;
      bit re;
      se = (s < v) ? s : v;
      mn = v - se;
      re = (h >= 360);
      r = v; g = v; b = v;
      if (!(inv || re || se == 0)) begin
         q    = (se * (h % 60)) / 60;
         rise = mn + q;
         fall = v - q;
         case (h / 60)
            0:       begin r = v;    g = rise; b = mn;   end
            1:       begin r = fall; g = v;    b = mn;   end
            2:       begin r = mn;   g = v;    b = rise; end
            3:       begin r = mn;   g = fall; b = v;    end
            4:       begin r = rise; g = mn;   b = v;    end
            default: begin r = v;    g = mn;   b = fall; end
         endcase
      end
      return {re, 1'b0, 5'(r), 5'(g), 5'(b)};
   endfunction

   function automatic int roundDiv(input int num, input int den);
      if (num >= 0) return (2 * num + den) / (2 * den);
      return -((-2 * num + den) / (2 * den));
   endfunction

   function automatic void rgbToHsv(input int r, input int g, input int b,
                                    output int h, output int s, output int v, output bit inv);
      int mx, mn, c;
      mx = (r > g) ? r : g; mx = (mx > b) ? mx : b;
      mn = (r < g) ? r : g; mn = (mn < b) ? mn : b;
      c = mx - mn; v = mx; s = c; h = 0; inv = (c == 0);
      if (c != 0) begin
         if (mx == r)      h = roundDiv(60 * (g - b), c);
         else if (mx == g) h = 120 + roundDiv(60 * (b - r), c);
         else              h = 240 + roundDiv(60 * (r - g), c);
         if (h < 0)    h += 360;
         if (h >= 360) h -= 360;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One full conversion from an idle DUT; lat is edges from accept to done (-1 on timeout).
   task automatic applyStimulus(input logic [8:0] h, input logic [4:0] s, input logic [4:0] v,
                                input logic inv, output int lat, output logic [15:0] d,
                                output logic re);
      @(negedge clk);
      hue = h; saturation = s; value = v; hue_invalid = inv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      d  = data;
      re = range_err;
   endtask

   initial begin
      int lat, t1, t2, hh, ss, vv, dr, dg, db;
      logic [15:0] d;
      logic re, seen;
      logic [16:0] exp;
      bit inv;

      res = 1'b0; start = 1'b0; hue = '0; saturation = '0; value = '0; hue_invalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_data", data, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_range_err", range_err, 0);
      @(negedge clk) res = 1'b1;

      vecs[0] = '{9'd0,   5'd31, 5'd31, 1'b0, 16'h7C00, 1'b0};
      vecs[1] = '{9'd120, 5'd31, 5'd31, 1'b0, 16'h03E0, 1'b0};
      vecs[2] = '{9'd240, 5'd31, 5'd31, 1'b0, 16'h001F, 1'b0};
      vecs[3] = '{9'd30,  5'd31, 5'd31, 1'b0, 16'h7DE0, 1'b0};
      vecs[4] = '{9'd300, 5'd20, 5'd25, 1'b0, 16'h64B9, 1'b0};
      vecs[5] = '{9'd77,  5'd12, 5'd16, 1'b1, 16'h4210, 1'b0};
      vecs[6] = '{9'd400, 5'd31, 5'd16, 1'b0, 16'h4210, 1'b1};
      vecs[7] = '{9'd0,   5'd31, 5'd10, 1'b0, 16'h2800, 1'b0};

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].h, vecs[i].s, vecs[i].v, vecs[i].inv, lat, d, re);
         checkOutput($sformatf("vec%0d_data", i), d, vecs[i].d);
         checkOutput($sformatf("vec%0d_range_err", i), re, vecs[i].re);
         checkOutput($sformatf("vec%0d_latency", i), lat, 18);
         checkOutput($sformatf("vec%0d_busy_at_done", i), busy, 0);
      end

      // A start pulse during MUL must be ignored.
      @(negedge clk);
      hue = 9'd120; saturation = 5'd31; value = 5'd31; hue_invalid = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) begin start = 1'b1; hue = 9'd0; end
         if (k == 6) start = 1'b0;
         if (done) begin lat = k; break; end
      end
      checkOutput("busy_start_latency", lat, 18);
      checkOutput("busy_start_data", data, 16'h03E0);
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1 if (done) seen = 1'b1;
      end
      checkOutput("busy_start_no_extra_done", seen, 0);

      // start held high: back-to-back conversions with done every 19 cycles.
      @(negedge clk);
      hue = 9'd240; saturation = 5'd31; value = 5'd31; hue_invalid = 1'b0; start = 1'b1;
      t1 = -1; t2 = -1;
      for (int k = 0; k < 80 && t2 < 0; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (t1 < 0) t1 = cycle;
            else begin t2 = cycle; start = 1'b0; end
         end
      end
      checkOutput("held_start_period", t2 - t1, 19);
      checkOutput("held_start_data", data, 16'h001F);
      repeat (25) @(posedge clk);

      // Reset at edge N+9 aborts the conversion.
      @(negedge clk);
      hue = 9'd60; saturation = 5'd31; value = 5'd31; hue_invalid = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk) res = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midreset_data", data, 0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_done", done, 0);
      @(negedge clk) res = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1 if (done || busy) seen = 1'b1;
      end
      checkOutput("midreset_stays_idle", seen, 0);

      for (int n = 0; n < 150; n++) begin
         hh  = $urandom_range(0, 399);
         ss  = $urandom_range(0, 31);
         vv  = $urandom_range(0, 31);
         inv = ($urandom_range(0, 15) == 0);
         exp = refModel(hh, ss, vv, inv);
         applyStimulus(9'(hh), 5'(ss), 5'(vv), inv, lat, d, re);
         checkOutput($sformatf("rand%0d_data h=%0d s=%0d v=%0d i=%0d", n, hh, ss, vv, inv), d, exp[15:0]);
         checkOutput($sformatf("rand%0d_range_err", n), re, exp[16]);
         checkOutput($sformatf("rand%0d_latency", n), lat, 18);
      end

      for (int n = 0; n < 332; n++) begin
         int r, g, b;
         if (n < 32) begin r = n; g = n; b = n; end
         else begin r = $urandom_range(0, 31); g = $urandom_range(0, 31); b = $urandom_range(0, 31); end
         rgbToHsv(r, g, b, hh, ss, vv, inv);
         applyStimulus(9'(hh), 5'(ss), 5'(vv), inv, lat, d, re);
         dr = int'(d[14:10]) - r; dg = int'(d[9:5]) - g; db = int'(d[4:0]) - b;
         checks++;
         if (inv ? (dr != 0 || dg != 0 || db != 0)
                 : (dr > 1 || dr < -1 || dg > 1 || dg < -1 || db > 1 || db < -1)) begin
            errors++;
            $display("[TB] FAIL roundtrip rgb=%0d,%0d,%0d actual=0x%0h hsv=%0d,%0d,%0d grey=%0d",
                     r, g, b, d, hh, ss, vv, inv);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
